// File: rtl/pdm_sd2_modulator_pkg.sv
// Shared widths, full-scale feedback levels and the saturating adder for the PDM transmit path.
// Integrator sums never wrap; they clamp to the symmetric accumulator range instead.
package pdm_pkg;

  localparam int PCM_W     = 16;
  localparam int FRAC_W    = 6;
  localparam int X_W       = PCM_W + FRAC_W;
  localparam int STEP_W    = PCM_W + 1;
  localparam int FS_POS    = 32768;
  localparam int FS_NEG    = -32768;
  localparam int LIMIT_DEF = 26214;

  // Symmetric clamp to +/-(2^(w-1)-1); the sum is formed one bit wider so it cannot wrap.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] s;
    logic signed [32:0] mx;
    s  = 33'(a) + 33'(b);
    mx = (33'sd1 <<< (w - 1)) - 33'sd1;
    if (s > mx) begin
      s = mx;
    end else if (s < -mx) begin
      s = -mx;
    end
    return 32'(s);
  endfunction

endpackage

// File: rtl/pdm_sd2_modulator_if.sv
// PCM sample handshake into the modulator: valid/ready with a signed 16-bit payload.
interface pdm_sd2_modulator_if;
  import pdm_pkg::*;

  logic signed [PCM_W-1:0] pcm_in;
  logic                    pcm_valid;
  logic                    pcm_ready;

  modport master (output pcm_in, output pcm_valid, input pcm_ready);
  modport slave  (input pcm_in, input pcm_valid, output pcm_ready);

endinterface

// File: rtl/pdm_sd2_modulator_sd2_core.sv
// Second-order sigma-delta loop: signed input u_i to a registered 1-bit stream, one bit per clock.
// u_i is used combinationally; pdm_o reflects it one clock later. No backpressure.
module sd2_core
  import pdm_pkg::*;
#(
  parameter int ACC_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [PCM_W-1:0] u_i,
  output logic                    pdm_o
);

  logic signed [ACC_WIDTH-1:0] i1_q, i2_q;
  logic signed [ACC_WIDTH-1:0] i1_d, i2_d;
  logic signed [31:0]          fb_neg;

  // Feedback is subtracted, so carry its negation into the adder.
  always_comb begin
    fb_neg = pdm_o ? 32'(FS_NEG) : 32'(FS_POS);
    i1_d   = ACC_WIDTH'(sat_add(32'(i1_q) + 32'(u_i), fb_neg, ACC_WIDTH));
    i2_d   = ACC_WIDTH'(sat_add(32'(i2_q) + 32'(i1_d), fb_neg, ACC_WIDTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i1_q  <= '0;
      i2_q  <= '0;
      pdm_o <= 1'b0;
    end else begin
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      pdm_o <= ~i2_d[ACC_WIDTH-1];
    end
  end

endmodule

// File: rtl/pdm_sd2_modulator.sv
// PCM-to-PDM transmitter: one-entry sample buffer, INTERP-fold hold/linear upsampler, 2nd-order SD loop.
// A sample taken before frame boundary k reaches u the cycle after k; pcm_ready is low while the buffer is full.
module pdm_sd2_modulator
  import pdm_pkg::*;
#(
  parameter int INTERP    = 64,
  parameter int ACC_WIDTH = 24,
  parameter int LIMIT     = LIMIT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  pdm_sd2_modulator_if.slave        pcm_if,
  input  logic                      interp_en,
  input  logic                      mute,
  output logic                      pdm_out,
  output logic                      sample_tick,
  output logic                      underrun
);

  localparam int PH_W = $clog2(INTERP);
  localparam logic signed [PCM_W-1:0] LIM_P = PCM_W'(LIMIT);
  localparam logic signed [PCM_W-1:0] LIM_N = -LIM_P;

  logic [PH_W-1:0]          phase_q;
  logic                     full_q;
  logic signed [PCM_W-1:0]  buf_q;
  logic signed [PCM_W-1:0]  target_q;
  logic signed [X_W-1:0]    x_q;
  logic signed [STEP_W-1:0] step_q;
  logic                     tick_q;
  logic                     und_q;

  logic                     boundary;
  logic                     accept;
  logic signed [PCM_W-1:0]  new_s;
  logic signed [PCM_W-1:0]  x_int;
  logic signed [PCM_W-1:0]  mod_u;

  assign boundary         = (phase_q == PH_W'(INTERP - 1));
  assign accept           = pcm_if.pcm_valid & ~full_q;
  assign pcm_if.pcm_ready = ~full_q;
  assign sample_tick      = tick_q;
  assign underrun         = und_q;

  // An empty buffer at the boundary repeats the last target rather than dropping to zero.
  assign new_s = full_q ? buf_q : target_q;
  assign x_int = x_q[X_W-1:FRAC_W];

  always_comb begin
    mod_u = x_int;
    if (mute) begin
      mod_u = '0;
    end else if (x_int > LIM_P) begin
      mod_u = LIM_P;
    end else if (x_int < LIM_N) begin
      mod_u = LIM_N;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= '0;
      full_q   <= 1'b0;
      buf_q    <= '0;
      target_q <= '0;
      x_q      <= '0;
      step_q   <= '0;
      tick_q   <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      phase_q <= phase_q + 1'b1;
      tick_q  <= 1'b0;
      und_q   <= 1'b0;
      if (boundary) begin
        if (full_q) begin
          full_q <= 1'b0;
          tick_q <= 1'b1;
        end else begin
          und_q  <= 1'b1;
        end
        target_q <= new_s;
        // Linear mode restarts from the old target; INTERP adds of step land exactly on the new one.
        if (interp_en) begin
          x_q    <= {target_q, {FRAC_W{1'b0}}};
          step_q <= STEP_W'(new_s) - STEP_W'(target_q);
        end else begin
          x_q    <= {new_s, {FRAC_W{1'b0}}};
          step_q <= '0;
        end
      end else begin
        x_q <= x_q + X_W'(step_q);
      end
      // Never coincides with a consume: ready is low whenever the buffer is full.
      if (accept) begin
        buf_q  <= pcm_if.pcm_in;
        full_q <= 1'b1;
      end
    end
  end

  sd2_core #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .u_i   (mod_u),
    .pdm_o (pdm_out)
  );

endmodule
